// File: rtl/core_pkg.sv
// Shared core types for the load path: lane count, VRF slice types,
// load descriptor and per-lane queue entry.
package core_pkg;

  localparam int unsigned NrLane       = 4;
  localparam int unsigned MaxLoadBeats = 15;

  typedef logic [31:0] vrf_data_t;
  typedef logic [3:0]  vrf_strb_t;
  typedef logic [7:0]  vrf_addr_t;
  typedef logic [3:0]  insn_id_t;

  typedef logic [$clog2(MaxLoadBeats+1)-1:0] load_beat_cnt_t;

  typedef struct packed {
    vrf_addr_t      vd_addr;
    load_beat_cnt_t nr_beats;
    insn_id_t       id;
  } load_req_t;

  typedef struct packed {
    vrf_data_t data;
    vrf_strb_t strb;
    vrf_addr_t addr;
    insn_id_t  id;
  } lane_load_entry_t;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_ACTIVE,
    LD_DONE
  } load_state_e;

endpackage

// File: rtl/load_op_distributor_fifo.sv
// Two-entry per-lane queue with a registered head; pop is ignored while empty.
module lane_load_fifo
  import core_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  lane_load_entry_t push_data,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output lane_load_entry_t data
);

  logic [1:0]       count_q;
  lane_load_entry_t head_q;
  lane_load_entry_t tail_q;
  logic             do_pop;

  assign do_pop = pop & (count_q != 2'd0);
  assign valid  = (count_q != 2'd0);
  assign full   = (count_q == 2'd2);
  assign data   = head_q;

  // Occupancy and storage update; the head register always holds the oldest entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; with one entry the new item becomes the head directly.
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/load_op_distributor.sv
// Splits memory response beats into per-lane VRF slices, buffers them per
// lane, and reports completion of the in-flight load to the launcher.
module load_op_distributor
  import core_pkg::*;
#(
  parameter int unsigned NrLane    = core_pkg::NrLane,
  parameter int unsigned DataWidth = $bits(vrf_data_t)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_req_valid_i,
  output logic                        load_req_ready_o,
  input  load_req_t                   load_req_i,
  input  logic                        mem_resp_valid_i,
  output logic                        mem_resp_ready_o,
  input  logic [NrLane*DataWidth-1:0] mem_resp_data_i,
  input  vrf_strb_t [NrLane-1:0]      mem_resp_strb_i,
  output logic [NrLane-1:0]           load_op_valid_o,
  input  logic [NrLane-1:0]           load_op_gnt_i,
  output vrf_data_t [NrLane-1:0]      load_op_o,
  output vrf_strb_t [NrLane-1:0]      load_op_strb_o,
  output vrf_addr_t [NrLane-1:0]      load_op_addr_o,
  output insn_id_t [NrLane-1:0]       load_id_o,
  output logic                        load_done_o,
  output insn_id_t                    load_done_id_o,
  input  logic                        load_done_gnt_i
);

  load_state_e    state_q, state_d;
  vrf_addr_t      vd_addr_q;
  insn_id_t       id_q;
  load_beat_cnt_t nr_beats_q;
  load_beat_cnt_t beat_idx_q;

  logic [NrLane-1:0] fifo_full;
  logic [NrLane-1:0] fifo_valid;
  logic [NrLane-1:0] drain_empty;
  logic              req_accept;
  logic              beat_accept;

  lane_load_entry_t push_entry [NrLane];
  lane_load_entry_t head_entry [NrLane];

  assign req_accept  = load_req_valid_i & load_req_ready_o;
  assign beat_accept = mem_resp_valid_i & mem_resp_ready_o;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LD_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d          = state_q;
    load_req_ready_o = 1'b0;
    mem_resp_ready_o = 1'b0;
    load_done_o      = 1'b0;
    load_done_id_o   = '0;
    case (state_q)
      LD_IDLE: begin
        load_req_ready_o = 1'b1;
        if (load_req_valid_i) begin
          state_d = (load_req_i.nr_beats == '0) ? LD_DONE : LD_ACTIVE;
        end
      end
      LD_ACTIVE: begin
        mem_resp_ready_o = (beat_idx_q < nr_beats_q) & ~|fifo_full;
        // Look ahead at this cycle's pops so done rises right after the final grant.
        if ((beat_idx_q == nr_beats_q) && (&drain_empty)) state_d = LD_DONE;
      end
      LD_DONE: begin
        load_done_o    = 1'b1;
        load_done_id_o = id_q;
        if (load_done_gnt_i) state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Descriptor capture and beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vd_addr_q  <= '0;
      id_q       <= '0;
      nr_beats_q <= '0;
      beat_idx_q <= '0;
    end else if (req_accept) begin
      vd_addr_q  <= load_req_i.vd_addr;
      id_q       <= load_req_i.id;
      nr_beats_q <= load_req_i.nr_beats;
      beat_idx_q <= '0;
    end else if (beat_accept) begin
      beat_idx_q <= beat_idx_q + load_beat_cnt_t'(1);
    end
  end

  for (genvar i = 0; i < NrLane; i++) begin : gen_lane
    assign push_entry[i].data = mem_resp_data_i[i*DataWidth +: DataWidth];
    assign push_entry[i].strb = mem_resp_strb_i[i];
    assign push_entry[i].addr = vd_addr_q + vrf_addr_t'(beat_idx_q);
    assign push_entry[i].id   = id_q;

    lane_load_fifo u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (beat_accept),
      .push_data (push_entry[i]),
      .full      (fifo_full[i]),
      .pop       (load_op_gnt_i[i]),
      .valid     (fifo_valid[i]),
      .data      (head_entry[i])
    );

    assign drain_empty[i]     = ~fifo_valid[i] | (load_op_gnt_i[i] & ~fifo_full[i]);
    assign load_op_valid_o[i] = fifo_valid[i];
    assign load_op_o[i]       = head_entry[i].data;
    assign load_op_strb_o[i]  = head_entry[i].strb;
    assign load_op_addr_o[i]  = head_entry[i].addr;
    assign load_id_o[i]       = head_entry[i].id;
  end

endmodule

// File: tb/tb_load_op_distributor.sv
// Self-checking bench: directed vector table, reset and random phases, all
// checked cycle by cycle against a queue-based model of the distributor.
module tb_load_op_distributor;
  import core_pkg::*;

  localparam int unsigned NL = core_pkg::NrLane;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  load_req_valid, load_req_ready;
  load_req_t             load_req;
  logic                  mem_valid, mem_ready;
  logic [NL*32-1:0]      mem_data;
  vrf_strb_t [NL-1:0]    mem_strb;
  logic [NL-1:0]         op_valid, op_gnt;
  vrf_data_t [NL-1:0]    op_data;
  vrf_strb_t [NL-1:0]    op_strb;
  vrf_addr_t [NL-1:0]    op_addr;
  insn_id_t [NL-1:0]     op_id;
  logic                  done, done_gnt;
  insn_id_t              done_id;

  load_op_distributor #(.NrLane(NL), .DataWidth(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .load_req_valid_i (load_req_valid),
    .load_req_ready_o (load_req_ready),
    .load_req_i       (load_req),
    .mem_resp_valid_i (mem_valid),
    .mem_resp_ready_o (mem_ready),
    .mem_resp_data_i  (mem_data),
    .mem_resp_strb_i  (mem_strb),
    .load_op_valid_o  (op_valid),
    .load_op_gnt_i    (op_gnt),
    .load_op_o        (op_data),
    .load_op_strb_o   (op_strb),
    .load_op_addr_o   (op_addr),
    .load_id_o        (op_id),
    .load_done_o      (done),
    .load_done_id_o   (done_id),
    .load_done_gnt_i  (done_gnt)
  );

  // Reference model: per-lane queues of expected slices plus instruction bookkeeping.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  addr;
    logic [3:0]  id;
  } exp_t;

  exp_t       mq [NL][$];
  bit         m_busy, m_done;
  int         m_sent, m_nr, m_base;
  logic [3:0] m_id;
  logic [7:0] seen0 [$];
  int         n_total = 0;
  int         n_pass  = 0;

  typedef struct {
    logic [7:0] vd;
    int         nr;
    logic [3:0] id;
    int         stall_lane;
    int         stall_len;
    int         ack_delay;
    int         exp_count;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_flush();
    m_busy = 0;
    m_done = 0;
    m_sent = 0;
    m_nr   = 0;
    for (int l = 0; l < NL; l++) mq[l].delete();
  endtask

  // Compare outputs against the model at mid-cycle, then advance the model over the next edge.
  task automatic step();
    bit      exp_mr, rq_acc, bt_acc, dn_acc, all_empty;
    bit [NL-1:0] pop;
    exp_t    e;
    exp_mr = m_busy && (m_sent < m_nr);
    for (int l = 0; l < NL; l++) if (mq[l].size() >= 2) exp_mr = 0;
    chk("req_ready", load_req_ready, !m_busy && !m_done);
    chk("mem_ready", mem_ready, exp_mr);
    chk("done", done, m_done);
    if (m_done) chk("done_id", done_id, m_id);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lane%0d_valid", l), op_valid[l], mq[l].size() > 0);
      if (mq[l].size() > 0 && op_valid[l]) begin
        chk($sformatf("lane%0d_data", l), op_data[l], mq[l][0].data);
        chk($sformatf("lane%0d_strb", l), op_strb[l], mq[l][0].strb);
        chk($sformatf("lane%0d_addr", l), op_addr[l], mq[l][0].addr);
        chk($sformatf("lane%0d_id", l), op_id[l], mq[l][0].id);
      end
    end
    rq_acc = load_req_valid && !m_busy && !m_done;
    bt_acc = mem_valid && exp_mr;
    dn_acc = m_done && done_gnt;
    for (int l = 0; l < NL; l++) pop[l] = op_gnt[l] && (mq[l].size() > 0);
    for (int l = 0; l < NL; l++) begin
      if (pop[l]) begin
        if (l == 0) seen0.push_back(mq[0][0].addr);
        void'(mq[l].pop_front());
      end
    end
    if (bt_acc) begin
      for (int l = 0; l < NL; l++) begin
        e.data = mem_data[l*32 +: 32];
        e.strb = mem_strb[l];
        e.addr = 8'(m_base + m_sent);
        e.id   = m_id;
        mq[l].push_back(e);
      end
      m_sent++;
    end
    if (dn_acc) m_done = 0;
    all_empty = 1;
    for (int l = 0; l < NL; l++) if (mq[l].size() != 0) all_empty = 0;
    if (rq_acc) begin
      m_base = int'(load_req.vd_addr);
      m_nr   = int'(load_req.nr_beats);
      m_id   = load_req.id;
      m_sent = 0;
      if (m_nr == 0) m_done = 1;
      else           m_busy = 1;
    end else if (m_busy && m_sent == m_nr && all_empty) begin
      m_busy = 0;
      m_done = 1;
    end
    @(negedge clk);
  endtask

  task automatic run_case(input logic [7:0] vd, input int nr, input logic [3:0] id,
                          input int stall_lane, input int stall_len, input int ack_delay,
                          input bit rnd, input int exp_count,
                          input logic [7:0] exp_first, input logic [7:0] exp_last);
    int cyc, dcnt;
    bit fin, started;
    seen0.delete();
    load_req.vd_addr  = vd;
    load_req.nr_beats = load_beat_cnt_t'(nr);
    load_req.id       = id;
    cyc = 0; dcnt = 0; fin = 0; started = 0;
    while (!fin && cyc < 400) begin
      load_req_valid = !started && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      mem_valid      = rnd ? ($urandom_range(0, 3) != 0) : started;
      for (int l = 0; l < NL; l++) begin
        mem_data[l*32 +: 32] = $urandom;
        mem_strb[l]          = 4'($urandom);
      end
      op_gnt = rnd ? NL'($urandom) : '1;
      if (!rnd && stall_len > 0 && cyc <= stall_len) op_gnt[stall_lane] = 1'b0;
      if (m_done) done_gnt = (dcnt >= ack_delay);
      else        done_gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (m_done) dcnt++;
      fin = m_done && done_gnt;
      if (load_req_valid && !m_busy && !m_done) started = 1;
      step();
      cyc++;
    end
    load_req_valid = 0;
    mem_valid      = 0;
    done_gnt       = 0;
    op_gnt         = '0;
    if (!fin) begin
      n_total++;
      $display("FAIL timeout: case id %0d did not complete, expected done ack", id);
    end
    chk("lane0_count", seen0.size(), exp_count);
    if (seen0.size() > 0 && exp_count > 0) begin
      chk("lane0_first_addr", seen0[0], exp_first);
      chk("lane0_last_addr", seen0[seen0.size()-1], exp_last);
    end
  endtask

  initial begin
    vt[0] = '{8'h10, 3, 4'd5, 0, 0, 0, 3, 8'h10, 8'h12};
    vt[1] = '{8'h10, 3, 4'd5, 2, 6, 0, 3, 8'h10, 8'h12};
    vt[2] = '{8'hFF, 2, 4'd3, 0, 0, 0, 2, 8'hFF, 8'h00};
    vt[3] = '{8'h20, 0, 4'd7, 0, 0, 0, 0, 8'h00, 8'h00};
    vt[4] = '{8'h40, 4, 4'd9, 1, 3, 4, 4, 8'h40, 8'h43};
    vt[5] = '{8'hF8, 15, 4'd12, 3, 2, 1, 15, 8'hF8, 8'h06};

    rst_n = 0;
    load_req_valid = 0; load_req = '0;
    mem_valid = 0; mem_data = '0; mem_strb = '0;
    op_gnt = '0; done_gnt = 0;
    model_flush();
    @(negedge clk);
    chk("rst_req_ready", load_req_ready, 1);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_valid", op_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_data", op_data[0] | op_data[NL-1], 0);
    chk("rst_addr", op_addr[1], 0);
    chk("rst_id", op_id[2], 0);
    chk("rst_done_id", done_id, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 6; i++)
      run_case(vt[i].vd, vt[i].nr, vt[i].id, vt[i].stall_lane, vt[i].stall_len,
               vt[i].ack_delay, 1'b0, vt[i].exp_count, vt[i].exp_first, vt[i].exp_last);

    // Reset after one of three beats: queues flush, no done is reported.
    load_req_valid = 1;
    load_req.vd_addr = 8'h30; load_req.nr_beats = load_beat_cnt_t'(3); load_req.id = 4'd2;
    step();
    load_req_valid = 0;
    mem_valid = 1;
    for (int l = 0; l < NL; l++) mem_data[l*32 +: 32] = $urandom;
    op_gnt = '0;
    step();
    mem_valid = 0;
    chk("pre_rst_valid", op_valid, {NL{1'b1}});
    rst_n = 0;
    #1;
    chk("mid_rst_valid", op_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mem_ready", mem_ready, 0);
    model_flush();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1;
      op_gnt = '1;
      done_gnt = 1;
      step();
    end
    mem_valid = 0; done_gnt = 0; op_gnt = '0;

    // Randomised descriptors, beat gaps and grant patterns.
    for (int i = 0; i < 25; i++) begin
      logic [7:0] rvd;
      int rnr;
      rvd = 8'($urandom);
      rnr = $urandom_range(0, 15);
      run_case(rvd, rnr, 4'($urandom), 0, 0, $urandom_range(0, 3), 1'b1,
               rnr, rvd, 8'(rvd + 8'(rnr) - 8'd1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
